// File: rtl/udp_pkg.sv
// Shared constants and FSM encoding for the UDP loopback scheduler.
package udp_pkg;
    localparam int LEN_W          = 16;
    localparam int GAP_CYCLES_DEF = 12;

    // S_GAP is the single pop/realign cycle; S_WAIT finishes the idle gap.
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_START = 5'b00010,
        S_SEND  = 5'b00100,
        S_GAP   = 5'b01000,
        S_WAIT  = 5'b10000
    } loop_state_t;
endpackage

// File: rtl/udp_pkt_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
module udp_pkt_ram #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data
);
    logic [7:0] r_mem [2**ADDR_W];
    logic [7:0] r_rd_data;

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/udp_loop_ctrl.sv
// Loopback scheduler: buffers received payloads with commit/rollback and
// replays each whole packet to the UDP transmitter one at a time.
module udp_loop_ctrl
    import udp_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int LEN_DEPTH  = 4,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rec_en,
    input  logic [7:0]       rec_data,
    input  logic             rec_pkt_done,
    input  logic [LEN_W-1:0] rec_byte_num,
    output logic             tx_start_en,
    output logic [LEN_W-1:0] tx_byte_num,
    input  logic             tx_req,
    output logic [7:0]       tx_data,
    input  logic             tx_done,
    output logic             busy,
    output logic [15:0]      drop_cnt
);
    localparam int PTR_W = ADDR_W + 1;
    localparam int Q_AW  = $clog2(LEN_DEPTH);
    localparam int Q_CW  = Q_AW + 1;

    loop_state_t      r_state, w_state_nxt;

    logic [PTR_W-1:0] r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic [PTR_W-1:0] w_used;
    logic             w_ram_full, w_wr_en, w_drop_fin;
    logic [LEN_W-1:0] r_pkt_cnt, w_pkt_cnt_fin;
    logic             r_drop;
    logic             w_commit, w_ignore, w_rollback;
    logic [15:0]      r_drop_cnt;

    logic [LEN_W-1:0] r_len_q [LEN_DEPTH];
    logic [Q_AW-1:0]  r_q_wp, r_q_rp;
    logic [Q_CW-1:0]  r_q_cnt;
    logic             w_q_full, w_q_empty, w_pop;

    logic             w_rd_en, r_rd_vld;
    logic [7:0]       w_ram_q;
    logic [LEN_W-1:0] r_rd_cnt, w_remain;
    logic [15:0]      r_gap_cnt;
    logic             r_tx_start_en, r_busy;
    logic [LEN_W-1:0] r_tx_byte_num;
    logic [7:0]       r_tx_data;

    // Occupancy comes from registered pointers, so a same-cycle read never frees space early.
    assign w_used        = r_wr_ptr - r_rd_ptr;
    assign w_ram_full    = (w_used == PTR_W'(2**ADDR_W));
    assign w_wr_en       = rec_en && !w_ram_full && !r_drop;
    assign w_drop_fin    = r_drop || (rec_en && w_ram_full);
    assign w_pkt_cnt_fin = r_pkt_cnt + LEN_W'(w_wr_en);

    assign w_q_full  = (r_q_cnt == Q_CW'(LEN_DEPTH));
    assign w_q_empty = (r_q_cnt == '0);

    assign w_ignore   = rec_pkt_done && (rec_byte_num == '0) && (w_pkt_cnt_fin == '0) && !w_drop_fin;
    assign w_commit   = rec_pkt_done && !w_drop_fin && (w_pkt_cnt_fin == rec_byte_num)
                        && (rec_byte_num != '0) && !w_q_full;
    assign w_rollback = rec_pkt_done && !w_commit && !w_ignore;

    assign w_remain = r_tx_byte_num - r_rd_cnt;

    udp_pkt_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (rec_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_pkt_cnt    <= '0;
            r_drop       <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_rollback) begin
                r_wr_ptr <= r_commit_ptr;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_commit) begin
                r_commit_ptr <= r_wr_ptr + PTR_W'(w_wr_en);
            end
            if (rec_pkt_done) begin
                r_pkt_cnt <= '0;
                r_drop    <= 1'b0;
            end else begin
                r_pkt_cnt <= w_pkt_cnt_fin;
                if (rec_en && w_ram_full) begin
                    r_drop <= 1'b1;
                end
            end
            if (w_rollback && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_len_q[r_q_wp] <= rec_byte_num;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_wp  <= '0;
            r_q_rp  <= '0;
            r_q_cnt <= '0;
        end else begin
            if (w_commit) begin
                r_q_wp <= r_q_wp + Q_AW'(1);
            end
            if (w_pop) begin
                r_q_rp <= r_q_rp + Q_AW'(1);
            end
            if (w_commit && !w_pop) begin
                r_q_cnt <= r_q_cnt + Q_CW'(1);
            end else if (!w_commit && w_pop) begin
                r_q_cnt <= r_q_cnt - Q_CW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_q_empty) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_rd_en = tx_req && (r_rd_cnt < r_tx_byte_num);
                if (tx_done) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                w_pop       = 1'b1;
                w_state_nxt = (GAP_CYCLES <= 1) ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (r_gap_cnt >= 16'(GAP_CYCLES - 2)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rd_ptr      <= '0;
            r_rd_cnt      <= '0;
            r_rd_vld      <= 1'b0;
            r_gap_cnt     <= '0;
            r_tx_start_en <= 1'b0;
            r_tx_byte_num <= '0;
            r_tx_data     <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_tx_start_en <= (r_state == S_START);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_rd_vld      <= w_rd_en;
            if (r_rd_vld) begin
                r_tx_data <= w_ram_q;
            end
            if (r_state == S_START) begin
                r_tx_byte_num <= r_len_q[r_q_rp];
                r_rd_cnt      <= '0;
            end else if (w_rd_en) begin
                r_rd_cnt <= r_rd_cnt + LEN_W'(1);
            end
            // An early tx_done skips the unread tail so the next packet starts aligned.
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else if ((r_state == S_GAP) && (r_rd_cnt < r_tx_byte_num)) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(w_remain);
            end
            if (r_state == S_GAP) begin
                r_gap_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_gap_cnt <= r_gap_cnt + 16'd1;
            end
        end
    end

    assign tx_start_en = r_tx_start_en;
    assign tx_byte_num = r_tx_byte_num;
    assign tx_data     = r_tx_data;
    assign busy        = r_busy;
    assign drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_udp_loop_ctrl.sv
// Bench for udp_loop_ctrl: instance 0 uses defaults, instance 1 a 16-byte RAM.
`timescale 1ns/1ps
module tb_udp_loop_ctrl;
    localparam int GAP = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        rst_n        [2];
    logic        rec_en       [2];
    logic [7:0]  rec_data     [2];
    logic        rec_pkt_done [2];
    logic [15:0] rec_byte_num [2];
    logic        tx_req       [2];
    logic        tx_done      [2];
    logic        tx_start_en  [2];
    logic [15:0] tx_byte_num  [2];
    logic [7:0]  tx_data      [2];
    logic        busy         [2];
    logic [15:0] drop_cnt     [2];

    udp_loop_ctrl u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n[0]),
        .rec_en       (rec_en[0]),
        .rec_data     (rec_data[0]),
        .rec_pkt_done (rec_pkt_done[0]),
        .rec_byte_num (rec_byte_num[0]),
        .tx_start_en  (tx_start_en[0]),
        .tx_byte_num  (tx_byte_num[0]),
        .tx_req       (tx_req[0]),
        .tx_data      (tx_data[0]),
        .tx_done      (tx_done[0]),
        .busy         (busy[0]),
        .drop_cnt     (drop_cnt[0])
    );

    udp_loop_ctrl #(.ADDR_W(4)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n[1]),
        .rec_en       (rec_en[1]),
        .rec_data     (rec_data[1]),
        .rec_pkt_done (rec_pkt_done[1]),
        .rec_byte_num (rec_byte_num[1]),
        .tx_start_en  (tx_start_en[1]),
        .tx_byte_num  (tx_byte_num[1]),
        .tx_req       (tx_req[1]),
        .tx_data      (tx_data[1]),
        .tx_done      (tx_done[1]),
        .busy         (busy[1]),
        .drop_cnt     (drop_cnt[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] len_q[$];
    logic [7:0]  last_byte = 8'h00;

    int start_cnt   [2] = '{0, 0};
    int start_cyc   [2] = '{0, 0};
    int starts_seen [2] = '{0, 0};
    int done_cyc    [2] = '{0, 0};
    bit have_done   [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (tx_start_en[k] === 1'b1) begin
                start_cnt[k]++;
                start_cyc[k] = cyc;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset(input int sel, input string tag);
        check_eq({tag, "_start"}, 32'(tx_start_en[sel]), 32'h0);
        check_eq({tag, "_bytenum"}, 32'(tx_byte_num[sel]), 32'h0);
        check_eq({tag, "_data"}, 32'(tx_data[sel]), 32'h0);
        check_eq({tag, "_busy"}, 32'(busy[sel]), 32'h0);
        check_eq({tag, "_drop"}, 32'(drop_cnt[sel]), 32'h0);
    endtask

    // Drives nbytes payload bytes; the last one carries rec_pkt_done when with_done.
    task automatic send_pkt(input int sel, input int nbytes, input int len,
                            input bit with_done, input bit expect_ok, input bit ramp);
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            b = ramp ? 8'(i) : 8'($urandom_range(0, 255));
            rec_en[sel]       = 1'b1;
            rec_data[sel]     = b;
            rec_pkt_done[sel] = with_done && (i == nbytes - 1);
            rec_byte_num[sel] = (with_done && (i == nbytes - 1)) ? 16'(len) : 16'h0;
            if (expect_ok) exp_q.push_back(b);
        end
        if (expect_ok) len_q.push_back(16'(len));
        @(negedge clk);
        rec_en[sel]       = 1'b0;
        rec_pkt_done[sel] = 1'b0;
        rec_byte_num[sel] = 16'h0;
    endtask

    // Issues n byte requests; every accepted request is compared two falling edges later.
    task automatic tx_bytes(input int sel, input int n, input bit slow);
        int issued = 0;
        int guard  = 0;
        bit p0 = 1'b0;
        bit p1 = 1'b0;
        logic [7:0] e;
        while ((issued < n || p0 || p1) && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (p1) begin
                if (exp_q.size() == 0) begin
                    check_eq("tx_data_underflow", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    last_byte = e;
                    check_eq("tx_data", 32'(tx_data[sel]), 32'(e));
                end
            end
            p1 = p0;
            if (issued < n && (!slow || $urandom_range(0, 2) == 0)) begin
                tx_req[sel] = 1'b1;
                p0 = 1'b1;
                issued++;
            end else begin
                tx_req[sel] = 1'b0;
                p0 = 1'b0;
            end
        end
        tx_req[sel] = 1'b0;
        if (guard >= 2000) check_eq("tx_bytes_timeout", 32'h1, 32'h0);
    endtask

    task automatic wait_start(input int sel, output logic [15:0] exp_len, output bit ok);
        int g = 0;
        exp_len = 16'h0;
        while (start_cnt[sel] <= starts_seen[sel] && g < 3000) begin
            @(negedge clk);
            g++;
        end
        ok = (start_cnt[sel] > starts_seen[sel]);
        check_eq("start_seen", 32'(ok), 32'h1);
        if (ok) begin
            starts_seen[sel]++;
            if (len_q.size() == 0) begin
                check_eq("len_q_underflow", 32'h1, 32'h0);
            end else begin
                exp_len = len_q.pop_front();
                check_eq("tx_byte_num", 32'(tx_byte_num[sel]), 32'(exp_len));
            end
            check_eq("busy_on_start", 32'(busy[sel]), 32'h1);
            if (have_done[sel]) begin
                check_eq("gap_after_done", 32'((start_cyc[sel] - done_cyc[sel]) >= GAP + 2), 32'h1);
            end
        end
    endtask

    task automatic tx_packet(input int sel, input int n_send, input bit slow, input bit hold_chk);
        logic [15:0] exp_len;
        bit ok;
        wait_start(sel, exp_len, ok);
        if (!ok) return;
        tx_bytes(sel, n_send, slow);
        if (hold_chk) begin
            @(negedge clk);
            tx_req[sel] = 1'b1;
            @(negedge clk);
            tx_req[sel] = 1'b0;
            idle(2);
            check_eq("tx_data_hold", 32'(tx_data[sel]), 32'(last_byte));
        end
        for (int i = n_send; i < int'(exp_len); i++) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        check_eq("tx_byte_num_stable", 32'(tx_byte_num[sel]), 32'(exp_len));
        @(negedge clk);
        tx_done[sel]   = 1'b1;
        done_cyc[sel]  = cyc;
        have_done[sel] = 1'b1;
        @(negedge clk);
        tx_done[sel] = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] l;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            rec_en[k] = 1'b0;
            rec_data[k] = 8'h0;
            rec_pkt_done[k] = 1'b0;
            rec_byte_num[k] = 16'h0;
            tx_req[k] = 1'b0;
            tx_done[k] = 1'b0;
        end
        idle(3);
        check_reset(0, "rst0");
        check_reset(1, "rst1");
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        idle(2);

        // Single 16-byte ramp packet, plus a request past the end that must not advance.
        fork
            send_pkt(0, 16, 16, 1'b1, 1'b1, 1'b1);
            tx_packet(0, 16, 1'b0, 1'b1);
        join
        check_eq("t1_drop", 32'(drop_cnt[0]), 32'h0);
        idle(GAP + 6);
        check_eq("t1_idle_busy", 32'(busy[0]), 32'h0);

        // Three back-to-back packets with a slow transmitter.
        fork
            begin
                for (int p = 0; p < 3; p++) send_pkt(0, 10, 10, 1'b1, 1'b1, 1'b0);
            end
            begin
                for (int p = 0; p < 3; p++) tx_packet(0, 10, 1'b1, 1'b0);
            end
        join
        check_eq("t2_drop", 32'(drop_cnt[0]), 32'h0);

        // Oversized packet into the 16-byte RAM rolls back; the next packet goes through.
        send_pkt(1, 20, 20, 1'b1, 1'b0, 1'b0);
        idle(30);
        check_eq("t3_drop", 32'(drop_cnt[1]), 32'h1);
        check_eq("t3_no_start", 32'(start_cnt[1]), 32'(starts_seen[1]));
        fork
            send_pkt(1, 8, 8, 1'b1, 1'b1, 1'b0);
            tx_packet(1, 8, 1'b0, 1'b0);
        join
        check_eq("t3_drop_after", 32'(drop_cnt[1]), 32'h1);

        // Short packet: 11 bytes against a declared length of 12.
        send_pkt(0, 11, 12, 1'b1, 1'b0, 1'b0);
        idle(30);
        check_eq("t4_short_drop", 32'(drop_cnt[0]), 32'h1);
        check_eq("t4_no_start", 32'(start_cnt[0]), 32'(starts_seen[0]));

        // Length queue full: fifth packet dropped while the transmitter stalls.
        for (int p = 0; p < 5; p++) send_pkt(0, 3, 3, 1'b1, p < 4, 1'b0);
        idle(4);
        check_eq("t4_full_drop", 32'(drop_cnt[0]), 32'h2);
        for (int p = 0; p < 4; p++) tx_packet(0, 3, 1'b0, 1'b0);

        // Early tx_done after 5 of 10 bytes, then a 4-byte packet must be aligned.
        fork
            send_pkt(0, 10, 10, 1'b1, 1'b1, 1'b0);
            tx_packet(0, 5, 1'b0, 1'b0);
        join
        fork
            send_pkt(0, 4, 4, 1'b1, 1'b1, 1'b0);
            tx_packet(0, 4, 1'b0, 1'b0);
        join
        check_eq("t5_drop", 32'(drop_cnt[0]), 32'h2);

        // Reset mid-transmit while the receiver is mid-packet.
        send_pkt(0, 10, 10, 1'b1, 1'b1, 1'b0);
        wait_start(0, l, ok);
        tx_bytes(0, 4, 1'b0);
        send_pkt(0, 5, 8, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        check_reset(0, "t6_rst");
        idle(2);
        rst_n[0] = 1'b1;
        exp_q.delete();
        len_q.delete();
        starts_seen[0] = start_cnt[0];
        have_done[0]   = 1'b0;
        send_pkt(0, 3, 8, 1'b1, 1'b0, 1'b0);
        idle(30);
        check_eq("t6_tail_drop", 32'(drop_cnt[0]), 32'h1);
        check_eq("t6_no_start", 32'(start_cnt[0]), 32'(starts_seen[0]));
        fork
            send_pkt(0, 6, 6, 1'b1, 1'b1, 1'b0);
            tx_packet(0, 6, 1'b0, 1'b0);
        join
        check_eq("t6_drop_after", 32'(drop_cnt[0]), 32'h1);

        idle(GAP + 6);
        check_eq("sb_data_empty", 32'(exp_q.size()), 32'h0);
        check_eq("sb_len_empty", 32'(len_q.size()), 32'h0);
        check_eq("final_busy", 32'(busy[0]), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
